// File: rtl/dl_pkg.sv
// Shared types and defaults for the download memory writer: FSM states,
// address/data widths and the FIFO entry width helper.
package dl_pkg;

  localparam int DL_ADDR_W = 25;
  localparam int DL_DATA_W = 16;

  localparam logic [DL_ADDR_W-1:0] DL_BASE_ADDR  = 25'h0E0000;
  localparam logic [DL_ADDR_W-1:0] DL_LIMIT_ADDR = 25'h140000;

  typedef enum logic {ST_IDLE, ST_REQ} dl_state_e;

  // A FIFO entry carries {word address, data word}.
  function automatic int dl_entry_w(input int mem_aw);
    return mem_aw + DL_DATA_W;
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO; head is visible combinationally, pop advances it next clk.
// A push on full is accepted when a pop happens in the same clk.
module dl_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dl_mem_writer.sv
// Window-checks loader words, buffers them and writes them to RAM via req/ack.
// Latency strobe edge -> mem_req is 2 clk; a full FIFO drops words (sticky overflow).
// DL_CHECKSUM_EN adds a mod-2^16 checksum of acked words.
module dl_mem_writer
  import dl_pkg::*;
#(
  parameter int                    DEPTH      = 8,
  parameter logic [DL_ADDR_W-1:0]  BASE_ADDR  = DL_BASE_ADDR,
  parameter logic [DL_ADDR_W-1:0]  LIMIT_ADDR = DL_LIMIT_ADDR,
  parameter int                    MEM_AW     = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic                  wr,
  input  logic [DL_ADDR_W-1:0]  a,
  input  logic [DL_DATA_W-1:0]  d,
  output logic                  mem_req,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DL_DATA_W-1:0]  mem_din,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7:0]            drop_cnt,
  output logic [MEM_AW-1:0]     word_cnt
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int EW = dl_entry_w(MEM_AW);
  localparam int CW = $clog2(DEPTH) + 1;

  dl_state_e            state;
  logic                 wr_d;
  logic                 dl_d;
  logic                 pend;
  logic                 push_ev;
  logic                 in_win;
  logic                 reject;
  logic                 lost;
  logic                 pop;
  logic                 dl_rise;
  logic                 dl_fall;
  logic [DL_ADDR_W-1:0] off;
  logic [EW-1:0]        push_dat;
  logic [EW-1:0]        head_dat;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        fifo_cnt;
  logic                 unused_off;

  assign push_ev    = wr & ~wr_d;
  assign in_win     = (a >= BASE_ADDR) && (a < LIMIT_ADDR);
  assign reject     = push_ev & ~in_win;
  assign off        = a - BASE_ADDR;
  assign push_dat   = {off[MEM_AW:1], d};
  assign unused_off = ^{off[DL_ADDR_W-1:MEM_AW+1], off[0]};

  // IDLE takes any queued head; REQ only moves on when the current word is acked.
  assign pop  = ~empty & ((state == ST_IDLE) | ((state == ST_REQ) & mem_ack));
  assign lost = push_ev & in_win & full & ~pop;

  assign dl_rise = downloading & ~dl_d;
  assign dl_fall = ~downloading & dl_d;
  assign busy    = (fifo_cnt != '0) | mem_req;
  assign done    = pend & ~busy;

  dl_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_ev & in_win),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_d     <= 1'b0;
      dl_d     <= 1'b0;
      pend     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      word_cnt <= '0;
`ifdef DL_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      wr_d <= wr;
      dl_d <= downloading;

      case (state)
        ST_IDLE: begin
          if (!empty) begin
            {mem_addr, mem_din} <= head_dat;
            mem_req             <= 1'b1;
            state               <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            word_cnt <= word_cnt + MEM_AW'(1);
`ifdef DL_CHECKSUM_EN
            checksum <= checksum + mem_din;
`endif
            if (!empty) begin
              {mem_addr, mem_din} <= head_dat;
            end else begin
              mem_req <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (reject && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (lost)    overflow <= 1'b1;
      if (done)    pend <= 1'b0;
      if (dl_fall) pend <= 1'b1;

      // A new download restarts all per-download status; queued words are kept.
      if (dl_rise) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
        word_cnt <= '0;
        pend     <= 1'b0;
`ifdef DL_CHECKSUM_EN
        checksum <= '0;
`endif
      end
    end
  end

endmodule
